par_to_ser: RTL and testbench
=============================

PAR_TO_SER -- requirements
Module: par_to_ser

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 16: bit width of one sample word.
- REQ-002 SHALL have parameter NUM_REGS, default 8: words per frame; legal values ≥2.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
- REQ-005 SHALL have port pDataIn, input, array [0:NUM_REGS-1] of DATA_WIDTH bits: the parallel frame to be loaded.
- REQ-006 SHALL have port loadValid, input, 1 bit: pDataIn holds a frame to be loaded.
- REQ-007 SHALL have port loadReady, output, 1 bit: the block can accept a frame.
- REQ-008 SHALL have port flush, input, 1 bit: synchronous abort of the frame in progress.
- REQ-009 SHALL have port sDataOut, output, DATA_WIDTH bits: the serial word being presented.
- REQ-010 SHALL have port sValid, output, 1 bit: sDataOut is valid.
- REQ-011 SHALL have port sReady, input, 1 bit: the downstream consumer accepts the word.
- REQ-012 SHALL have port sLast, output, 1 bit: sDataOut is the final word of the frame.
- REQ-013 SHALL have port wordIdx, output, $clog2(NUM_REGS) bits: index of the word currently presented.

Function
- REQ-014 SHALL implement two states, IDLE and SHIFT.
- REQ-015 SHALL drive loadReady=1 in IDLE and loadReady=0 in SHIFT.
- REQ-016 SHALL, on a load handshake (loadValid && loadReady) with flush=0, capture all NUM_REGS words of pDataIn into internal storage, set wordIdx=0 and enter SHIFT on the same edge.
- REQ-017 SHALL ignore pDataIn changes after capture until the next load handshake.
- REQ-018 SHALL drive sValid=1 only in SHIFT, with sDataOut = stored word[wordIdx]; word[0] is presented in the first cycle after the load edge (1-cycle latency).
- REQ-019 SHALL hold sDataOut, sLast and wordIdx stable while sValid=1 and sReady=0 (stall).
- REQ-020 SHALL, on an output handshake (sValid && sReady) with wordIdx < NUM_REGS-1, increment wordIdx by 1.
- REQ-021 SHALL drive sLast=1 exactly when sValid=1 and wordIdx == NUM_REGS-1.
- REQ-022 SHALL, on the output handshake with sLast=1, return to IDLE and reset wordIdx to 0; loadReady=1 in the next cycle, giving exactly one idle cycle between back-to-back frames.
- REQ-023 SHALL ignore sReady while in IDLE.
- REQ-024 SHALL, when flush=1 in SHIFT, return to IDLE on that edge with wordIdx=0 and sValid=0 next cycle; any simultaneous output handshake still transfers the word presented in that cycle, and the remaining words are discarded.
- REQ-025 SHALL, when flush=1 in IDLE, block a simultaneous load (flush has priority) and remain in IDLE.
- REQ-026 SHALL drive sDataOut=0 whenever sValid=0.
- REQ-027 SHALL pass words bit-exact with no arithmetic, sign extension or truncation.

Reset
- REQ-028 SHALL, while rst=0 (asynchronous, at any time including mid-frame), force state=IDLE, wordIdx=0, sValid=0, sLast=0, sDataOut=0, loadReady=1 and clear the storage to 0.
- REQ-029 SHALL, after rst deasserts, accept a load on the first rising edge at which loadValid=1.

Verification
- REQ-030 Basic frame: load 1..8 with sReady held at 1 -> sDataOut=1,2,...,8 on 8 consecutive cycles starting 1 cycle after the load; sLast=1 only with word 8; loadReady=1 in the following cycle.
- REQ-031 Backpressure: load 10..17, sReady=0 for 3 cycles while the word 12 is presented -> 12 held with wordIdx=2 for all 3 cycles; no word lost or duplicated; full sequence 10..17.
- REQ-032 Back-to-back: loadValid held at 1 with frames A=1..8 then B=9..16 -> 16 words in order with exactly one sValid=0 cycle between 8 and 9.
- REQ-033 Flush: flush asserted while word 4 of 1..8 is presented and sReady=1 -> word 4 transferred; sValid=0 next cycle; the next frame 20..27 starts at 20.
- REQ-034 Mid-frame reset: rst=0 asynchronously during word 5 -> sValid, sLast and sDataOut go to 0 immediately and loadReady=1; after release, a load of 30..37 yields 30..37.
- REQ-035 Input isolation: pDataIn changed to all 0xFFFF on the cycle after the load of 1..8 -> output is still 1..8.

Source files
------------

// File: rtl/par_to_ser.sv
// par_to_ser: captures a parallel frame of NUM_REGS words in one handshake and
// presents it one word per output handshake, with backpressure and flush.
//
// state | meaning
// IDLE  | waiting for a frame; loadReady=1, nothing presented
// SHIFT | presenting stored word[wordIdx] on sDataOut with sValid=1
module par_to_ser #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       pDataIn [0:NUM_REGS-1],
  input  logic                        loadValid,
  output logic                        loadReady,
  input  logic                        flush,
  output logic [DATA_WIDTH-1:0]       sDataOut,
  output logic                        sValid,
  input  logic                        sReady,
  output logic                        sLast,
  output logic [$clog2(NUM_REGS)-1:0] wordIdx
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [DATA_WIDTH-1:0] mem [0:NUM_REGS-1];
  logic                  load_hs;
  logic                  out_hs;

  // Outputs are decoded from registered state only, so reset clears them at once.
  assign loadReady = (state == IDLE);
  assign sValid    = (state == SHIFT);
  assign sLast     = sValid && (idx == LAST_IDX);
  assign sDataOut  = sValid ? mem[idx] : '0;
  assign wordIdx   = idx;

  // Flush outranks a load presented in the same cycle.
  assign load_hs = loadValid && loadReady && !flush;
  assign out_hs  = sValid && sReady;

  // State and word index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state and next-index logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (load_hs) begin
          state_nxt = SHIFT;
          idx_nxt   = '0;
        end
      end
      SHIFT: begin
        if (flush) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (out_hs) begin
          if (sLast) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Frame storage: written only on a load handshake, so later pDataIn changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (load_hs) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= pDataIn[i];
    end
  end

endmodule

// File: tb/tb_par_to_ser.sv
// Directed, table-driven bench for par_to_ser (DATA_WIDTH=16, NUM_REGS=8).
module tb_par_to_ser;

  localparam int DW = 16;
  localparam int NR = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] pDataIn [0:NR-1];
  logic          loadValid;
  logic          loadReady;
  logic          flush;
  logic [DW-1:0] sDataOut;
  logic          sValid;
  logic          sReady;
  logic          sLast;
  logic [2:0]    wordIdx;

  int n_chk  = 0;
  int n_fail = 0;

  par_to_ser #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .pDataIn  (pDataIn),
    .loadValid(loadValid),
    .loadReady(loadReady),
    .flush    (flush),
    .sDataOut (sDataOut),
    .sValid   (sValid),
    .sReady   (sReady),
    .sLast    (sLast),
    .wordIdx  (wordIdx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected in that cycle (before the next rising edge).
  typedef struct {
    logic        lv;
    logic        fl;
    logic        sr;
    logic        ones;
    logic [15:0] base;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic [2:0]  ei;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge; pDataIn is base+i or all ones.
  task automatic drive(input logic lv, input logic fl, input logic sr,
                       input logic [15:0] base, input logic ones);
    @(negedge clk);
    loadValid = lv;
    flush     = fl;
    sReady    = sr;
    for (int i = 0; i < NR; i++) pDataIn[i] = ones ? 16'hFFFF : base + 16'(i);
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [15:0] ed,
                         input logic el, input logic [2:0] ei, input logic er);
    chk({tag, " sValid"},    32'(sValid),    32'(ev));
    chk({tag, " sDataOut"},  32'(sDataOut),  32'(ed));
    chk({tag, " sLast"},     32'(sLast),     32'(el));
    chk({tag, " wordIdx"},   32'(wordIdx),   32'(ei));
    chk({tag, " loadReady"}, 32'(loadReady), 32'(er));
  endtask

  // Expect IDLE in this cycle.
  task automatic idle_v(input logic lv, input logic fl, input logic [15:0] base, input logic ones);
    vec_t v;
    v.lv = lv; v.fl = fl; v.sr = 1'b1; v.ones = ones; v.base = base;
    v.ev = 1'b0; v.ed = 16'h0; v.el = 1'b0; v.ei = 3'd0; v.er = 1'b1;
    vecs.push_back(v);
  endtask

  // Expect word 'data' presented at index 'idx' in this cycle.
  task automatic word_v(input logic lv, input logic fl, input logic sr, input logic [15:0] base,
                        input logic ones, input int data, input int idx);
    vec_t v;
    v.lv = lv; v.fl = fl; v.sr = sr; v.ones = ones; v.base = base;
    v.ev = 1'b1; v.ed = 16'(data); v.el = (idx == NR - 1); v.ei = 3'(idx); v.er = 1'b0;
    vecs.push_back(v);
  endtask

  initial begin
    rst       = 1'b0;
    loadValid = 1'b0;
    flush     = 1'b0;
    sReady    = 1'b0;
    for (int i = 0; i < NR; i++) pDataIn[i] = '0;

    // Reset state, with loadValid and sReady active to show they are ignored.
    #2;
    loadValid = 1'b1;
    sReady    = 1'b1;
    @(posedge clk);
    #1 chk_out("reset", 1'b0, 16'h0, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    loadValid = 1'b0;
    rst       = 1'b1;
    #1 chk_out("post_reset", 1'b0, 16'h0, 1'b0, 3'd0, 1'b1);

    // Basic frame 1..8.
    idle_v(1, 0, 16'd1, 0);
    for (int k = 1; k <= 8; k++) word_v(0, 0, 1, 16'd0, 0, k, k - 1);
    idle_v(0, 0, 16'd0, 0);

    // Input isolation: pDataIn all ones from the cycle after the load.
    idle_v(1, 0, 16'd1, 0);
    for (int k = 1; k <= 8; k++) word_v(0, 0, 1, 16'd0, 1, k, k - 1);
    idle_v(0, 0, 16'd0, 0);

    // Backpressure: 12 stalled for 3 cycles, 17 (last) stalled once.
    idle_v(1, 0, 16'd10, 0);
    word_v(0, 0, 1, 16'd0, 0, 10, 0);
    word_v(0, 0, 1, 16'd0, 0, 11, 1);
    for (int s = 0; s < 3; s++) word_v(0, 0, 0, 16'd0, 0, 12, 2);
    for (int k = 12; k <= 16; k++) word_v(0, 0, 1, 16'd0, 0, k, k - 10);
    word_v(0, 0, 0, 16'd0, 0, 17, 7);
    word_v(0, 0, 1, 16'd0, 0, 17, 7);
    idle_v(0, 0, 16'd0, 0);

    // Back-to-back frames with loadValid held high.
    idle_v(1, 0, 16'd1, 0);
    for (int k = 1; k <= 8; k++) word_v(1, 0, 1, 16'd9, 0, k, k - 1);
    idle_v(1, 0, 16'd9, 0);
    for (int k = 9; k <= 16; k++) word_v(1, 0, 1, 16'd100, 0, k, k - 9);
    idle_v(0, 0, 16'd0, 0);

    // Flush in IDLE blocks a simultaneous load.
    idle_v(1, 1, 16'd50, 0);
    idle_v(0, 0, 16'd0, 0);

    // Flush while word 4 is transferred; next frame starts at 20.
    idle_v(1, 0, 16'd1, 0);
    for (int k = 1; k <= 3; k++) word_v(0, 0, 1, 16'd0, 0, k, k - 1);
    word_v(0, 1, 1, 16'd0, 0, 4, 3);
    idle_v(1, 0, 16'd20, 0);
    for (int k = 20; k <= 27; k++) word_v(0, 0, 1, 16'd0, 0, k, k - 20);
    idle_v(0, 0, 16'd0, 0);

    // Flush during a stall on the first word.
    idle_v(1, 0, 16'd40, 0);
    word_v(0, 1, 0, 16'd0, 0, 40, 0);
    idle_v(0, 0, 16'd0, 0);

    foreach (vecs[n]) begin
      drive(vecs[n].lv, vecs[n].fl, vecs[n].sr, vecs[n].base, vecs[n].ones);
      #1 chk_out($sformatf("vec%0d", n), vecs[n].ev, vecs[n].ed, vecs[n].el, vecs[n].ei, vecs[n].er);
    end

    // Mid-frame asynchronous reset during word 5, then a load of 30..37.
    drive(1, 0, 1, 16'd1, 0);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1, 16'd0, 0);
      #1 chk_out($sformatf("mr_w%0d", k), 1'b1, 16'(k), 1'b0, 3'(k - 1), 1'b0);
    end
    drive(0, 0, 0, 16'd0, 0);
    #1 chk_out("mr_w5", 1'b1, 16'd5, 1'b0, 3'd4, 1'b0);
    #2 rst = 1'b0;
    #1 chk_out("mr_in_reset", 1'b0, 16'h0, 1'b0, 3'd0, 1'b1);
    drive(1, 0, 1, 16'd30, 0);
    rst = 1'b1;
    #1 chk_out("mr_release", 1'b0, 16'h0, 1'b0, 3'd0, 1'b1);
    for (int k = 30; k <= 37; k++) begin
      drive(0, 0, 1, 16'd0, 0);
      #1 chk_out($sformatf("mr_w%0d", k), 1'b1, 16'(k), k == 37, 3'(k - 30), 1'b0);
    end
    drive(0, 0, 1, 16'd0, 0);
    #1 chk_out("mr_end", 1'b0, 16'h0, 1'b0, 3'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
